// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, access owner and default widths.
package dmem_arb_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned AW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU M stage and a DMA port.
// CPU has priority; a starvation counter forces one DMA win after MAX_WAIT losses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_valid,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ready,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned LW = $clog2(MEM_LAT + 1);
  localparam int unsigned SW = $clog2(MAX_WAIT + 1);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [DW-1:0] resp_q, resp_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic cpu_req, starved, grant_dma, grant_cpu, in_resp;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign starved   = (starve_cnt_q == SW'(MAX_WAIT));
  assign grant_dma = (state_q == IDLE) && dma_valid && (!cpu_req || starved);
  assign grant_cpu = (state_q == IDLE) && !grant_dma && cpu_req;

  always_comb begin
    // NOTE: every variable gets its hold/idle value first so no path can infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    resp_d       = resp_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_dma) begin
          owner_d      = OWN_DMA;
          mem_en_d     = 1'b1;
          mem_we_d     = dma_we;
          mem_addr_d   = dma_addr;
          mem_wdata_d  = dma_wdata;
          starve_cnt_d = '0;
          state_d      = ACCESS;
        end else if (grant_cpu) begin
          owner_d     = OWN_CPU;
          mem_en_d    = 1'b1;
          mem_we_d    = cpu_wr;  // rd and wr together is a write
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          if (dma_valid && !starved) starve_cnt_d = starve_cnt_q + SW'(1);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        lat_cnt_d = LW'(1);
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == LW'(MEM_LAT)) begin
          resp_d  = mem_rdata;
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      resp_q       <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      resp_q       <= resp_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Responses are suppressed while reset is held so an in-flight access never completes.
  assign in_resp    = (state_q == RESP) && !reset;
  assign cpu_ack    = in_resp && (owner_q == OWN_CPU);
  assign dma_rvalid = in_resp && (owner_q == OWN_DMA);
  assign cpu_rdata  = cpu_ack ? resp_q : '0;
  assign dma_rdata  = dma_rvalid ? resp_q : '0;
  assign dma_ready  = grant_dma && !reset;
  assign cpu_stall  = cpu_req && !cpu_ack && !reset;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU M stage and a DMA/loader port.
- Serialises accesses and applies a fixed memory latency.
- Asserts cpu_stall so the pipeline freezes while the CPU access is not yet served.
- CPU has priority. A starvation counter guarantees DMA forward progress.

Parameters:
- DW, 16: data word width.
- AW, 16: word address width.
- MEM_LAT, 1: cycles from the mem_en cycle to mem_rdata valid (≥1).
- MAX_WAIT, 4: consecutive lost IDLE arbitrations after which DMA wins once (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpu_rd  in  1  M-stage memRead.
- cpu_wr  in  1  M-stage memWrite.
- cpu_addr  in  AW  M-stage address.
- cpu_wdata  in  DW  M-stage store data.
- cpu_rdata  out  DW  load data; valid when cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  freeze IF/ID/EX/M; = (cpu_rd|cpu_wr) & ~cpu_ack & ~reset.
- dma_valid  in  1  DMA request.
- dma_we  in  1  DMA write.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA store data.
- dma_ready  out  1  request accepted this cycle (combinational).
- dma_rdata  out  DW  DMA load data.
- dma_rvalid  out  1  one-cycle DMA completion pulse.
- mem_en  out  1  memory access strobe (registered).
- mem_we  out  1  write enable (registered).
- mem_addr  out  AW  memory address (registered).
- mem_wdata  out  DW  memory write data (registered).
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset values: all outputs 0, state IDLE, starve_cnt 0, lat_cnt 0.
- Reset mid-access: return to IDLE and drop the in-flight response. No ack/rvalid is produced for it.
- States: IDLE, ACCESS, WAIT, RESP. The owner register (CPU/DMA) is latched at grant.
- IDLE, no request: remain in IDLE.
- IDLE, grant: latch owner and request fields; go to ACCESS.
  - Grant DMA if dma_valid and (no CPU request or starve_cnt==MAX_WAIT).
  - Otherwise grant CPU if a CPU request is present.
- dma_ready=1 only in IDLE in the cycle DMA is granted.
- ACCESS (1 cycle): mem_en=1, mem_we/addr/wdata from latched fields; lat_cnt=1; go to WAIT.
- WAIT: mem_en=0. In the cycle lat_cnt==MEM_LAT, capture mem_rdata into the response register and go to RESP; otherwise lat_cnt++.
- RESP (1 cycle):
  - Owner CPU: cpu_ack=1, cpu_rdata=captured.
  - Owner DMA: dma_rvalid=1, dma_rdata=captured.
  - Go to IDLE. A new grant is possible next cycle.
- Writes follow the identical sequence. The ack carries rdata=captured, don't-care.
- CPU timing, request first visible in cycle 0:
  - mem_en in cycle 1.
  - Capture in cycle 1+MEM_LAT.
  - cpu_ack in cycle 2+MEM_LAT.
  - cpu_stall high for cycles 0..1+MEM_LAT.
- The CPU holds its request stable while stalled; the pipeline advances at the end of the ack cycle.
- DMA must hold dma_valid and its fields stable until dma_ready. Same latency as the CPU.
- cpu_rd & cpu_wr both high: treated as a write.
- A CPU request during a DMA access keeps cpu_stall high until its own ack.
- starve_cnt:
  - Increments in each IDLE cycle where dma_valid=1 and CPU is granted.
  - Saturates at MAX_WAIT.
  - Clears on DMA grant.
  - Unchanged otherwise.
- Simultaneous requests: CPU wins unless starve_cnt==MAX_WAIT.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE/ACCESS/WAIT/RESP), owner enum (OWN_CPU/OWN_DMA), DW/AW defaults.
- Single module, no sub-module. Counters are inline.

Test Plan:
- CPU load alone, MEM_LAT=1, mem[0x0010]=0xBEEF, cpu_rd cycle 0: mem_en cycle 1 with addr 0x0010; cpu_stall high cycles 0–2; cpu_ack and cpu_rdata=0xBEEF in cycle 3.
- CPU store 0x1234→0x0020, then load 0x0020: mem_we=1 on the first access; the second ack returns 0x1234; stall drops exactly in each ack cycle.
- DMA write alone, addr 0x0005 data 0x00AA: dma_ready in cycle 0; mem_en/we cycle 1; dma_rvalid cycle 3; no cpu_stall.
- Continuous CPU loads plus constant dma_valid, MAX_WAIT=4: CPU wins 4 arbitrations, DMA wins the 5th (dma_ready=1); starve_cnt returns to 0; cpu_stall extends by one full access.
- MEM_LAT=3, CPU load: cpu_ack in cycle 5; stall cycles 0–4.
- Reset asserted during WAIT of a CPU load: the next cycle all outputs are 0 and state is IDLE; no cpu_ack is ever issued; a re-issued load after reset completes normally.
